hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 16, meaning number of architectural registers (index width 4).
REQ-002 SHALL have parameter CNT_W, default 2, meaning per-register in-flight write counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports src1, src2  input  4 each  decoded source register indices.
REQ-006 SHALL have ports has_rn, two_src  input  1 each  src1 / src2 actually read.
REQ-007 SHALL have ports issue_valid, issue_wb_en, issue_mem_r_en  input  1 each  instruction leaving decode, its writeback enable, its load flag.
REQ-008 SHALL have port issue_dest  input  4  destination of the issuing instruction.
REQ-009 SHALL have ports wb_en / wb_dest  input  1 / 4  register-file write this cycle.
REQ-010 SHALL have ports fwd_en, drain_req  input  1 each  forwarding-unit present; request pipeline drain.
REQ-011 SHALL have port hazard  output  1  stall decode (combinational from state and sources).
REQ-012 SHALL have ports busy_mask  output  16 (counter != 0 per register), drain_done  output  1 (single-cycle pulse), sb_err  output  1 (sticky error).

Function
REQ-013 SHALL keep one CNT_W-bit counter per register; accepted issue = issue_valid & issue_wb_en & !hazard.
REQ-014 SHALL increment cnt[issue_dest] on accepted issue and decrement cnt[wb_dest] on wb_en, same edge.
REQ-015 SHALL leave the counter unchanged when both events target the same register in one cycle.
REQ-016 SHALL saturate at 2^CNT_W-1 on increment and hold at 0 on decrement, setting sb_err in either case.
REQ-017 SHALL, with fwd_en=0, assert hazard = (has_rn & cnt[src1]!=0) | (two_src & cnt[src2]!=0).
REQ-018 SHALL, with fwd_en=1, assert hazard only for load-use: a one-cycle load tag (valid, dest) captured on accepted issue with issue_mem_r_en, compared against src1/src2 under has_rn/two_src.
REQ-019 SHALL clear the load tag on the cycle after capture unless another load is accepted.
REQ-020 SHALL implement FSM RUN, DRAIN, DONE: RUN->DRAIN on drain_req; DRAIN forces hazard=1; DRAIN->DONE when all counters zero and load tag invalid; DONE pulses drain_done one cycle and returns to RUN.
REQ-021 SHALL, if drain_req arrives while counters already zero, still pass through DRAIN for one cycle (drain_done two cycles after request).
REQ-022 SHALL ignore drain_req while in DRAIN or DONE.
REQ-023 SHALL still count writebacks while in DRAIN; no issues are accepted there.
REQ-024 SHALL treat writes to any register index (including 15) identically.

Reset
REQ-025 SHALL on rst low, asynchronously: all counters 0, load tag invalid, state RUN, sb_err 0, drain_done 0.
REQ-026 SHALL, during reset, drive hazard 0 and busy_mask 0.
REQ-027 SHALL discard in-progress drain when reset asserts mid-DRAIN; no drain_done follows.

Structure
REQ-028 SHALL take NREG, CNT_W and the FSM state encoding from the shared core package.
REQ-029 SHALL instantiate one sub-module sb_counter (per-register up/down saturating counter with error output), NREG instances.

Verification
REQ-030 SHALL cover: issue dest=3 fwd_en=0, next cycle src1=3 has_rn=1 -> hazard=1 until wb_en wb_dest=3, then hazard=0, busy_mask[3]=0.
REQ-031 SHALL cover: fwd_en=1, load issue dest=5, next cycle src2=5 two_src=1 -> hazard=1 for exactly one cycle; same with non-load -> hazard=0.
REQ-032 SHALL cover: simultaneous issue dest=7 and wb_dest=7 with cnt[7]=1 -> cnt[7] stays 1, busy_mask[7]=1.
REQ-033 SHALL cover: four issues to dest=2 with no writeback -> counter holds 3, sb_err=1; wb_en to empty register 9 -> sb_err=1.
REQ-034 SHALL cover: two writes pending, drain_req -> hazard=1, drain_done pulses one cycle after last wb_en; drain_req with nothing pending -> drain_done 2 cycles later.
REQ-035 SHALL cover: rst low mid-DRAIN with cnt[4]=2 -> all outputs 0 immediately, no drain_done after release.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared core definitions for the hazard scoreboard: register-file geometry,
// counter width and the drain FSM encoding.
package hazard_scoreboard_pkg;

  localparam int unsigned DefNreg = 16;
  localparam int unsigned DefCntW = 2;
  localparam int unsigned RegW    = 4;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register in-flight write counter: up on issue, down on writeback,
// saturating at both ends with a one-cycle error flag when a limit is hit.
module sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic busy,
  output logic busy_next,
  output logic err
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Coincident inc and dec cancel: the count and error flag are untouched.
  always_comb begin
    cnt_d = cnt_q;
    err   = 1'b0;
    if (inc && !dec) begin
      if (cnt_q == CntMax) err = 1'b1;
      else                 cnt_d = cnt_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_q == '0) err = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign busy      = (cnt_q != '0);
  assign busy_next = (cnt_d != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Register hazard scoreboard: per-register in-flight write counters, load-use
// tag for the forwarding case, and a drain FSM that stalls decode until idle.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = DefNreg,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RegW-1:0] src1,
  input  logic [RegW-1:0] src2,
  input  logic            has_rn,
  input  logic            two_src,
  input  logic            issue_valid,
  input  logic            issue_wb_en,
  input  logic            issue_mem_r_en,
  input  logic [RegW-1:0] issue_dest,
  input  logic            wb_en,
  input  logic [RegW-1:0] wb_dest,
  input  logic            fwd_en,
  input  logic            drain_req,
  output logic            hazard,
  output logic [NREG-1:0] busy_mask,
  output logic            drain_done,
  output logic            sb_err
);

  logic [NREG-1:0] inc, dec, busy_next, cnt_err;
  logic            accept, raw_hazard, all_idle_next;
  logic            tag_valid_q, tag_valid_d;
  logic [RegW-1:0] tag_dest_q, tag_dest_d;
  logic            sb_err_q;
  sb_state_e       state_q, state_d;

  for (genvar i = 0; i < NREG; i++) begin : g_cnt
    assign inc[i] = accept && (issue_dest == RegW'(i));
    assign dec[i] = wb_en && (wb_dest == RegW'(i));

    sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc[i]),
      .dec      (dec[i]),
      .busy     (busy_mask[i]),
      .busy_next(busy_next[i]),
      .err      (cnt_err[i])
    );
  end

  // With forwarding only a load result arriving too late can stall.
  always_comb begin
    raw_hazard = 1'b0;
    if (fwd_en) begin
      raw_hazard = tag_valid_q && ((has_rn && (src1 == tag_dest_q)) ||
                                   (two_src && (src2 == tag_dest_q)));
    end else begin
      raw_hazard = (has_rn && busy_mask[src1]) || (two_src && busy_mask[src2]);
    end
  end

  assign hazard = raw_hazard || (state_q == StDrain);
  assign accept = issue_valid && issue_wb_en && !hazard;

  always_comb begin
    tag_valid_d = accept && issue_mem_r_en;
    tag_dest_d  = tag_valid_d ? issue_dest : tag_dest_q;
  end

  // Idle is judged on post-edge state so DONE follows the last writeback directly.
  assign all_idle_next = (busy_next == '0) && !tag_valid_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (drain_req) state_d = StDrain;
      StDrain: if (all_idle_next) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      tag_valid_q <= 1'b0;
      tag_dest_q  <= '0;
      sb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_valid_q <= tag_valid_d;
      tag_dest_q  <= tag_dest_d;
      sb_err_q    <= sb_err_q || (|cnt_err);
    end
  end

  assign drain_done = (state_q == StDone);
  assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src1, src2, issue_dest, wb_dest;
  logic        has_rn, two_src, issue_valid, issue_wb_en, issue_mem_r_en;
  logic        wb_en, fwd_en, drain_req;
  logic        hazard, drain_done, sb_err;
  logic [15:0] busy_mask;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .src1          (src1),
    .src2          (src2),
    .has_rn        (has_rn),
    .two_src       (two_src),
    .issue_valid   (issue_valid),
    .issue_wb_en   (issue_wb_en),
    .issue_mem_r_en(issue_mem_r_en),
    .issue_dest    (issue_dest),
    .wb_en         (wb_en),
    .wb_dest       (wb_dest),
    .fwd_en        (fwd_en),
    .drain_req     (drain_req),
    .hazard        (hazard),
    .busy_mask     (busy_mask),
    .drain_done    (drain_done),
    .sb_err        (sb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    has_rn = 0; two_src = 0; src1 = 0; src2 = 0;
    issue_valid = 0; issue_wb_en = 0; issue_mem_r_en = 0; issue_dest = 0;
    wb_en = 0; wb_dest = 0; drain_req = 0;
  endtask

  task automatic issue(input logic [3:0] d, input logic ld);
    issue_valid = 1; issue_wb_en = 1; issue_mem_r_en = ld; issue_dest = d;
  endtask

  task automatic no_issue();
    issue_valid = 0; issue_wb_en = 0; issue_mem_r_en = 0;
  endtask

  task automatic wb(input logic [3:0] d);
    wb_en = 1; wb_dest = d;
  endtask

  task automatic reset_pulse();
    rst = 0;
    #1;
    cyc();
    rst = 1;
  endtask

  initial begin
    idle();
    fwd_en = 0;
    rst = 0;
    #3;
    check("reset_hazard", 32'(hazard), 32'd0);
    check("reset_busy", 32'(busy_mask), 32'd0);
    check("reset_drain_done", 32'(drain_done), 32'd0);
    check("reset_sb_err", 32'(sb_err), 32'd0);
    cyc();
    rst = 1;
    cyc();

    // Non-forwarding RAW on r3
    issue(4'd3, 1'b0);
    #1 check("raw_issue_no_hazard", 32'(hazard), 32'd0);
    cyc();
    no_issue();
    src1 = 4'd3; has_rn = 1;
    #1 check("raw_hazard_src1", 32'(hazard), 32'd1);
    check("raw_busy3", 32'(busy_mask), 32'h0008);
    issue(4'd6, 1'b0);  // must be blocked by the stall
    cyc();
    no_issue();
    #1 check("raw_blocked_issue", 32'(busy_mask), 32'h0008);
    check("raw_hazard_hold", 32'(hazard), 32'd1);
    has_rn = 0; src2 = 4'd3; two_src = 0;
    #1 check("raw_src2_unused", 32'(hazard), 32'd0);
    two_src = 1;
    #1 check("raw_src2_used", 32'(hazard), 32'd1);
    wb(4'd3);
    #1 check("raw_hazard_during_wb", 32'(hazard), 32'd1);
    cyc();
    wb_en = 0;
    #1 check("raw_cleared_hazard", 32'(hazard), 32'd0);
    check("raw_cleared_busy", 32'(busy_mask), 32'd0);
    idle();

    // Forwarding: load-use stalls exactly one cycle, ALU result does not
    fwd_en = 1;
    issue(4'd5, 1'b1);
    cyc();
    no_issue();
    src2 = 4'd5; two_src = 1;
    #1 check("ld_use_hazard", 32'(hazard), 32'd1);
    cyc();
    #1 check("ld_use_one_cycle", 32'(hazard), 32'd0);
    check("ld_busy5", 32'(busy_mask), 32'h0020);
    two_src = 0;
    wb(4'd5);
    cyc();
    wb_en = 0;
    issue(4'd5, 1'b0);
    cyc();
    no_issue();
    two_src = 1;
    #1 check("alu_fwd_no_hazard", 32'(hazard), 32'd0);
    check("alu_busy5", 32'(busy_mask), 32'h0020);
    two_src = 0;
    wb(4'd5);
    cyc();
    wb_en = 0;
    fwd_en = 0;
    idle();
    #1 check("fwd_busy_clear", 32'(busy_mask), 32'd0);

    // Simultaneous issue and writeback to r7 leaves its count at 1
    issue(4'd7, 1'b0);
    cyc();
    wb(4'd7);
    cyc();
    no_issue(); wb_en = 0;
    #1 check("same_reg_busy7", 32'(busy_mask), 32'h0080);
    check("same_reg_no_err", 32'(sb_err), 32'd0);
    wb(4'd7);
    cyc();
    wb_en = 0;
    #1 check("same_reg_single_wb", 32'(busy_mask), 32'd0);

    // Register 15
    issue(4'd15, 1'b0);
    cyc();
    no_issue();
    #1 check("r15_busy", 32'(busy_mask), 32'h8000);
    wb(4'd15);
    cyc();
    wb_en = 0;
    #1 check("r15_clear", 32'(busy_mask), 32'd0);

    // Saturation at 3 on r2
    issue(4'd2, 1'b0);
    for (int i = 0; i < 3; i++) cyc();
    #1 check("sat_no_err_yet", 32'(sb_err), 32'd0);
    cyc();
    no_issue();
    #1 check("sat_err", 32'(sb_err), 32'd1);
    wb(4'd2);
    cyc(); cyc();
    wb_en = 0;
    #1 check("sat_after_two_wb", 32'(busy_mask), 32'h0004);
    wb(4'd2);
    cyc();
    wb_en = 0;
    #1 check("sat_after_three_wb", 32'(busy_mask), 32'd0);
    check("sat_err_sticky", 32'(sb_err), 32'd1);
    reset_pulse();
    #1 check("err_cleared_by_reset", 32'(sb_err), 32'd0);

    // Underflow on empty r9
    wb(4'd9);
    cyc();
    wb_en = 0;
    #1 check("underflow_err", 32'(sb_err), 32'd1);
    check("underflow_busy", 32'(busy_mask), 32'd0);
    reset_pulse();

    // Drain with two pending writes
    issue(4'd1, 1'b0);
    cyc();
    issue(4'd4, 1'b0);
    cyc();
    no_issue();
    drain_req = 1;
    cyc();
    drain_req = 0;
    #1 check("drain_hazard", 32'(hazard), 32'd1);
    check("drain_no_done", 32'(drain_done), 32'd0);
    issue(4'd8, 1'b0);
    cyc();
    no_issue();
    #1 check("drain_blocks_issue", 32'(busy_mask), 32'h0012);
    wb(4'd1);
    cyc();
    #1 check("drain_wb1_busy", 32'(busy_mask), 32'h0010);
    check("drain_wb1_not_done", 32'(drain_done), 32'd0);
    wb(4'd4);
    cyc();
    wb_en = 0;
    #1 check("drain_done_pulse", 32'(drain_done), 32'd1);
    check("drain_done_busy", 32'(busy_mask), 32'd0);
    cyc();
    #1 check("drain_done_single", 32'(drain_done), 32'd0);
    check("drain_back_to_run", 32'(hazard), 32'd0);

    // Drain with nothing pending: DRAIN for one cycle, done two cycles later
    drain_req = 1;
    cyc();
    drain_req = 0;
    #1 check("empty_drain_hazard", 32'(hazard), 32'd1);
    check("empty_drain_not_done", 32'(drain_done), 32'd0);
    cyc();
    #1 check("empty_drain_done", 32'(drain_done), 32'd1);
    cyc();
    #1 check("empty_drain_done_off", 32'(drain_done), 32'd0);

    // Reset in the middle of a drain
    issue(4'd4, 1'b0);
    cyc(); cyc();
    no_issue();
    drain_req = 1;
    cyc();
    drain_req = 0;
    #1 check("rst_drain_hazard_pre", 32'(hazard), 32'd1);
    check("rst_drain_busy_pre", 32'(busy_mask), 32'h0010);
    rst = 0;
    #1 check("rst_drain_hazard", 32'(hazard), 32'd0);
    check("rst_drain_busy", 32'(busy_mask), 32'd0);
    check("rst_drain_done", 32'(drain_done), 32'd0);
    check("rst_drain_err", 32'(sb_err), 32'd0);
    cyc();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1 check("rst_drain_no_done", 32'(drain_done), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
